// File: rtl/model_ps2_ascii_pkg.sv
// Shared scancode constants and decoder state encoding for the PS/2
// keyboard front end.
package model_ps2_ascii_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    localparam logic [3:0] LAST_BIT = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BREAK     = 2'd1,
        ST_EXT       = 2'd2,
        ST_EXT_BREAK = 2'd3
    } dec_state_e;

    // bits[0]=start, bits[8:1]=data, bits[9]=odd parity
    function automatic logic frame_ok(input logic [9:0] bits,
                                      input logic stop);
        return ~bits[0] & (^bits[9:1]) & stop;
    endfunction

endpackage

// File: rtl/model_scancode_rom.sv
// Set-2 scancode to ASCII lookup; hit=0 for codes with no character.
module model_scancode_rom (
    input  logic [7:0] code,
    input  logic       shift,
    output logic [7:0] ascii,
    output logic       hit
);

    logic [7:0] lo;
    logic [7:0] hi;

    always_comb begin
        lo = 8'd0;
        hi = 8'd0;
        case (code)
            8'h1C: lo = "a";  8'h32: lo = "b";
            8'h21: lo = "c";  8'h23: lo = "d";
            8'h24: lo = "e";  8'h2B: lo = "f";
            8'h34: lo = "g";  8'h33: lo = "h";
            8'h43: lo = "i";  8'h3B: lo = "j";
            8'h42: lo = "k";  8'h4B: lo = "l";
            8'h3A: lo = "m";  8'h31: lo = "n";
            8'h44: lo = "o";  8'h4D: lo = "p";
            8'h15: lo = "q";  8'h2D: lo = "r";
            8'h1B: lo = "s";  8'h2C: lo = "t";
            8'h3C: lo = "u";  8'h2A: lo = "v";
            8'h1D: lo = "w";  8'h22: lo = "x";
            8'h35: lo = "y";  8'h1A: lo = "z";
            8'h16: lo = "1";  8'h1E: lo = "2";
            8'h26: lo = "3";  8'h25: lo = "4";
            8'h2E: lo = "5";  8'h36: lo = "6";
            8'h3D: lo = "7";  8'h3E: lo = "8";
            8'h45: begin lo = "0"; hi = ")"; end
            8'h46: begin lo = "9"; hi = "("; end
            8'h29: begin lo = 8'd32; hi = 8'd32; end
            8'h5A: begin lo = 8'd10; hi = 8'd10; end
            8'h55: lo = "=";
            8'h5D: lo = 8'd92;
            8'h49: lo = ".";
            default: lo = 8'd0;
        endcase
        if (lo >= "a" && lo <= "z") begin
            hi = lo - 8'd32;
        end
        ascii = shift ? hi : lo;
        hit   = (ascii != 8'd0);
    end

endmodule

// File: rtl/model_ps2_ascii.sv
// PS/2 receiver and set-2 decoder producing one ASCII byte per key press
// for the lexer byte stream; idle output is 8'd0.
module model_ps2_ascii
    import model_ps2_ascii_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 25000,
    parameter int TIMEOUT_W      = 16
) (
    input  logic       clk_25mhz,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err
);

    localparam logic [TIMEOUT_W-1:0] WD_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);
    localparam logic [TIMEOUT_W-1:0] WD_ONE   = TIMEOUT_W'(1);

    logic [1:0]           clk_sync_q, dat_sync_q;
    logic                 clk_prev_q;
    logic [3:0]           cnt_q, cnt_d;
    logic [9:0]           shift_q, shift_d;
    logic [TIMEOUT_W-1:0] wd_q, wd_d;
    logic [7:0]           code_q, code_d;
    logic                 code_vld_q, code_vld_d;
    logic                 err_q, err_d;
    dec_state_e           state_q;
    logic                 shift_l_q, shift_r_q;
    logic [7:0]           data_out_q;
    logic                 data_valid_q;
    logic                 fall, stop_ok;
    logic [7:0]           rom_ascii;
    logic                 rom_hit;
    logic                 brk, ext;

    assign fall    = clk_prev_q & ~clk_sync_q[1];
    assign stop_ok = frame_ok(shift_q, dat_sync_q[1]);

    always_comb begin
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        wd_d       = wd_q;
        code_d     = code_q;
        code_vld_d = 1'b0;
        err_d      = 1'b0;
        if (fall) begin
            wd_d = '0;
            if (cnt_q == LAST_BIT) begin
                cnt_d      = 4'd0;
                code_d     = shift_q[8:1];
                code_vld_d = stop_ok;
                err_d      = ~stop_ok;
            end else begin
                cnt_d   = cnt_q + 4'd1;
                shift_d = {dat_sync_q[1], shift_q[9:1]};
            end
        end else if (cnt_q == 4'd0) begin
            wd_d = '0;
        end else if (wd_q + WD_ONE == WD_LIMIT) begin
            // stalled partial frame: drop it and flag
            wd_d  = '0;
            cnt_d = 4'd0;
            err_d = 1'b1;
        end else begin
            wd_d = wd_q + WD_ONE;
        end
    end

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
            cnt_q      <= 4'd0;
            shift_q    <= '0;
            wd_q       <= '0;
            code_q     <= 8'd0;
            code_vld_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
            clk_prev_q <= clk_sync_q[1];
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            wd_q       <= wd_d;
            code_q     <= code_d;
            code_vld_q <= code_vld_d;
            err_q      <= err_d;
        end
    end

    model_scancode_rom u_rom (
        .code  (code_q),
        .shift (shift_l_q | shift_r_q),
        .ascii (rom_ascii),
        .hit   (rom_hit)
    );

    assign brk = (state_q == ST_BREAK) || (state_q == ST_EXT_BREAK);
    assign ext = (state_q == ST_EXT);

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            shift_l_q    <= 1'b0;
            shift_r_q    <= 1'b0;
            data_out_q   <= 8'd0;
            data_valid_q <= 1'b0;
        end else begin
            data_out_q   <= 8'd0;
            data_valid_q <= 1'b0;
            if (code_vld_q) begin
                priority case (1'b1)
                    code_q == SC_BREAK:
                        state_q <= (state_q == ST_IDLE) ? ST_BREAK : ST_EXT_BREAK;
                    code_q == SC_EXT:
                        state_q <= brk ? ST_EXT_BREAK : ST_EXT;
                    brk: begin
                        if (code_q == SC_LSHIFT) shift_l_q <= 1'b0;
                        if (code_q == SC_RSHIFT) shift_r_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                    ext:                 state_q   <= ST_IDLE;
                    code_q == SC_LSHIFT: shift_l_q <= 1'b1;
                    code_q == SC_RSHIFT: shift_r_q <= 1'b1;
                    default: begin
                        data_out_q   <= rom_hit ? rom_ascii : 8'd0;
                        data_valid_q <= rom_hit;
                    end
                endcase
            end
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_model_ps2_ascii.sv
// Bench for model_ps2_ascii: directed scenarios plus randomized scancode
// streams checked against a keyboard-level reference model.
module tb_model_ps2_ascii;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stop_cyc = 0;
    int err_cyc = 0;
    int err_seen = 0;
    int out_q[$];
    int out_cyc_q[$];
    bit prev_v = 1'b0;
    bit prev_e = 1'b0;

    // reference keyboard model
    bit m_brk, m_ext, m_sl, m_sr;
    int exp_q[$];
    int exp_err;

    logic [7:0] let_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B,
        8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44,
        8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
        8'h35, 8'h1A};
    logic [7:0] dig_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
        8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] oth_sc [5] = '{8'h29, 8'h5A, 8'h55, 8'h5D, 8'h49};

    model_ps2_ascii dut (
        .clk_25mhz  (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err)
    );

    always #20 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid) begin
            out_q.push_back(int'(data_out));
            out_cyc_q.push_back(cyc);
        end
        if (frame_err) begin
            err_seen++;
            err_cyc = cyc;
        end
        if (!reset) begin
            checks++;
            if (((data_out != 8'd0) !== data_valid) || (data_valid && prev_v)
                || (frame_err && prev_e)) begin
                errors++;
                $display("FAIL strobe: data_out=%0d valid=%0b prev_valid=%0b err=%0b prev_err=%0b, required single-cycle valid with nonzero byte",
                         data_out, data_valid, prev_v, frame_err, prev_e);
            end
        end
        prev_v = data_valid;
        prev_e = frame_err;
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end

    function automatic int ascii_of(input logic [7:0] c, input bit sh);
        for (int i = 0; i < 26; i++)
            if (c == let_sc[i]) return sh ? 65 + i : 97 + i;
        for (int i = 0; i < 10; i++)
            if (c == dig_sc[i]) begin
                if (!sh) return 48 + i;
                if (i == 9) return 40;
                if (i == 0) return 41;
                return -1;
            end
        case (c)
            8'h29: return 32;
            8'h5A: return 10;
            8'h55: return sh ? -1 : 61;
            8'h5D: return sh ? -1 : 92;
            8'h49: return sh ? -1 : 46;
            default: return -1;
        endcase
    endfunction

    task automatic model_feed(input logic [7:0] c, input bit bad);
        int a;
        if (bad) begin
            exp_err++;
            return;
        end
        if (c == 8'hF0) m_brk = 1;
        else if (c == 8'hE0) m_ext = 1;
        else if (m_brk) begin
            if (c == 8'h12) m_sl = 0;
            if (c == 8'h59) m_sr = 0;
            m_brk = 0;
            m_ext = 0;
        end else if (m_ext) m_ext = 0;
        else if (c == 8'h12) m_sl = 1;
        else if (c == 8'h59) m_sr = 1;
        else begin
            a = ascii_of(c, m_sl | m_sr);
            if (a >= 0) exp_q.push_back(a);
        end
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat ($urandom_range(4, 10)) @(negedge clk);
        ps2_clk = 1'b0;
        stop_cyc = cyc;
        repeat ($urandom_range(4, 10)) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_bits(input logic [7:0] c, input bit bad, input int n);
        logic [10:0] f;
        f = {1'b1, (~^c) ^ bad, c, 1'b0};
        for (int i = 0; i < n; i++) ps2_bit(f[i]);
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] c, input bit bad);
        send_bits(c, bad, 11);
        model_feed(c, bad);
    endtask

    task automatic settle();
        repeat (12) @(negedge clk);
    endtask

    task automatic clear();
        out_q.delete();
        out_cyc_q.delete();
        err_seen = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (data_out !== 8'd0) begin
            errors++;
            $display("FAIL reset_data: got %0d required 0", data_out);
        end
        checks++;
        if (data_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %0b required 0", data_valid);
        end
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: got %0b required 0", frame_err);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single();
        int lat;
        clear();
        send_frame(8'h1C, 0);
        settle();
        checks++;
        if (out_q.size() !== 1 || out_q[0] !== 97) begin
            errors++;
            $display("FAIL single_a: got %0d bytes first=%0d required one byte 97",
                     out_q.size(), out_q.size() ? out_q[0] : -1);
        end
        lat = out_cyc_q.size() ? out_cyc_q[0] - stop_cyc : -1;
        checks++;
        if (lat < 4 || lat > 6) begin
            errors++;
            $display("FAIL single_latency: got %0d cycles pin-to-output required 4..6", lat);
        end
        checks++;
        if (err_seen !== 0) begin
            errors++;
            $display("FAIL single_err: got %0d frame_err pulses required 0", err_seen);
        end
    endtask

    task automatic test_break();
        clear();
        send_frame(8'hF0, 0);
        send_frame(8'h1C, 0);
        settle();
        checks++;
        if (out_q.size() !== 0) begin
            errors++;
            $display("FAIL break_silent: got %0d bytes required 0", out_q.size());
        end
        send_frame(8'h1C, 0);
        settle();
        checks++;
        if (out_q.size() !== 1 || out_q[0] !== 97) begin
            errors++;
            $display("FAIL break_then_make: got %0d bytes first=%0d required one byte 97",
                     out_q.size(), out_q.size() ? out_q[0] : -1);
        end
    endtask

    task automatic test_back_to_back();
        clear();
        for (int i = 0; i < 3; i++) send_frame(8'h29, 0);
        settle();
        checks++;
        if (out_q.size() !== 3 || out_q[0] !== 32 || out_q[2] !== 32) begin
            errors++;
            $display("FAIL repeat_space: got %0d bytes required three 32s", out_q.size());
        end
    endtask

    task automatic test_shift();
        clear();
        send_frame(8'h12, 0);
        send_frame(8'h46, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h12, 0);
        send_frame(8'h45, 0);
        settle();
        checks++;
        if (out_q.size() !== 2 || out_q[0] !== 40 || out_q[1] !== 48) begin
            errors++;
            $display("FAIL shift_paren: got %0d bytes first=%0d second=%0d required 40 then 48",
                     out_q.size(), out_q.size() > 0 ? out_q[0] : -1,
                     out_q.size() > 1 ? out_q[1] : -1);
        end
    endtask

    task automatic test_parity();
        clear();
        send_frame(8'h5D, 1);
        settle();
        checks++;
        if (err_seen !== 1 || out_q.size() !== 0) begin
            errors++;
            $display("FAIL parity_err: got %0d pulses %0d bytes required 1 pulse 0 bytes",
                     err_seen, out_q.size());
        end
        send_frame(8'h5D, 0);
        settle();
        checks++;
        if (out_q.size() !== 1 || out_q[0] !== 92 || err_seen !== 1) begin
            errors++;
            $display("FAIL parity_recover: got %0d bytes first=%0d pulses=%0d required 92 and 1 pulse",
                     out_q.size(), out_q.size() ? out_q[0] : -1, err_seen);
        end
    endtask

    task automatic test_timeout();
        int waited;
        clear();
        send_bits(8'h33, 0, 5);
        waited = 0;
        while (err_seen == 0 && waited < 25200) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (err_seen !== 1) begin
            errors++;
            $display("FAIL timeout_pulse: got %0d pulses after %0d cycles required 1",
                     err_seen, waited);
        end
        checks++;
        if (err_cyc - stop_cyc < 25001 || err_cyc - stop_cyc > 25005) begin
            errors++;
            $display("FAIL timeout_delay: got %0d cycles from last edge required 25001..25005",
                     err_cyc - stop_cyc);
        end
        send_frame(8'h49, 0);
        settle();
        checks++;
        if (out_q.size() !== 1 || out_q[0] !== 46 || err_seen !== 1) begin
            errors++;
            $display("FAIL timeout_recover: got %0d bytes first=%0d pulses=%0d required 46",
                     out_q.size(), out_q.size() ? out_q[0] : -1, err_seen);
        end
    endtask

    task automatic test_reset_midframe();
        int bad;
        clear();
        send_frame(8'h12, 0);
        send_bits(8'h1C, 0, 6);
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (data_out !== 8'd0 || data_valid !== 1'b0 || frame_err !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_outputs: got %0d nonzero cycles required 0", bad);
        end
        reset = 1'b0;
        m_brk = 0; m_ext = 0; m_sl = 0; m_sr = 0;
        repeat (3) @(negedge clk);
        clear();
        send_frame(8'h1C, 0);
        settle();
        checks++;
        if (out_q.size() !== 1 || out_q[0] !== 97 || err_seen !== 0) begin
            errors++;
            $display("FAIL reset_lower: got %0d bytes first=%0d pulses=%0d required 97",
                     out_q.size(), out_q.size() ? out_q[0] : -1, err_seen);
        end
    endtask

    task automatic test_random();
        logic [7:0] c;
        int r, idx;
        bit bad;
        clear();
        exp_q.delete();
        exp_err = 0;
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 99);
            if (r < 10) c = 8'hF0;
            else if (r < 14) c = 8'hE0;
            else if (r < 20) c = 8'h12;
            else if (r < 24) c = 8'h59;
            else if (r < 30) c = 8'($urandom_range(0, 255));
            else begin
                idx = $urandom_range(0, 40);
                if (idx < 26) c = let_sc[idx];
                else if (idx < 36) c = dig_sc[idx - 26];
                else c = oth_sc[idx - 36];
            end
            bad = ($urandom_range(0, 9) == 0);
            send_frame(c, bad);
        end
        settle();
        checks++;
        if (out_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL random_count: got %0d bytes required %0d",
                     out_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (out_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL random_byte[%0d]: got %0d required %0d",
                             i, out_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (err_seen !== exp_err) begin
            errors++;
            $display("FAIL random_err: got %0d pulses required %0d", err_seen, exp_err);
        end
    endtask

    initial begin
        m_brk = 0; m_ext = 0; m_sl = 0; m_sr = 0;
        exp_err = 0;
        test_reset();
        test_single();
        test_break();
        test_back_to_back();
        test_shift();
        test_parity();
        test_timeout();
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
